led_alarm_ctrl: RTL and testbench

//   Parametrised alarm LED driver for the control-center LEDR bank. Shows steady-on

---
 rtl/led_alarm_ctrl.sv | 90 +++++++++
 tb/tb_led_alarm_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/led_alarm_ctrl.sv
// led_alarm_ctrl: alarm LED driver with standby, four latched alarm patterns and an acknowledged state.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   alarm_in     alarm request level
//   ack          one-cycle acknowledge pulse
//   clear        one-cycle clear pulse
//   mode         alarm pattern select (0 slow, 1 fast, 2 alternating, 3 chase)
//   LEDR         registered LED drive, 1 = lit
//   alarm_active registered, high in ALARM or ACKED
//   acked        registered, high in ACKED
module led_alarm_ctrl #(
  parameter int N_LED   = 12,
  parameter int CLK_HZ  = 50_000_000,
  parameter int SLOW_HZ = 1,
  parameter int FAST_HZ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alarm_in,
  input  logic             ack,
  input  logic             clear,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] LEDR,
  output logic             alarm_active,
  output logic             acked
);
  localparam int SLOW_HALF = CLK_HZ / (2 * SLOW_HZ);
  localparam int FAST_HALF = CLK_HZ / (2 * FAST_HZ);
  localparam int SW = $clog2(SLOW_HALF + 1);
  localparam int FW = $clog2(FAST_HALF + 1);
  typedef enum logic [1:0] {IDLE, ALARM, ACKED} state_t;
  state_t state, nxt;
  logic [SW-1:0] slow_cnt;
  logic [FW-1:0] fast_cnt;
  logic slow_ph, fast_ph, alarm_prev, rise, slow_wrap, fast_wrap, enter;
  logic [N_LED-1:0] chase, alt, led_nxt;
  assign rise      = alarm_in & ~alarm_prev;
  assign slow_wrap = slow_cnt == SW'(SLOW_HALF - 1);
  assign fast_wrap = fast_cnt == FW'(FAST_HALF - 1);
  // rising alarm wins over clear in ACKED; clear only drops to IDLE once the alarm is gone
  assign nxt = state == IDLE  ? (alarm_in ? ALARM : IDLE) :
               state == ALARM ? (ack ? ACKED : ALARM) :
               rise ? ALARM : (clear & ~alarm_in) ? IDLE : ACKED;
  assign enter = nxt == ALARM && state != ALARM;
  always_comb begin
    alt = '0;
    for (int i = 0; i < N_LED; i++) alt[i] = (i % 2 == 0) ? slow_ph : ~slow_ph;
  end
  assign led_nxt = state == IDLE  ? '1 :
                   state == ACKED ? {{(N_LED-1){1'b0}}, slow_ph} :
                   mode == 2'd0   ? {N_LED{slow_ph}} :
                   mode == 2'd1   ? {N_LED{fast_ph}} :
                   mode == 2'd2   ? alt : chase;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      LEDR         <= '0;
      alarm_active <= 1'b0;
      acked        <= 1'b0;
      slow_cnt     <= '0;
      fast_cnt     <= '0;
      slow_ph      <= 1'b1;
      fast_ph      <= 1'b1;
      chase        <= N_LED'(1);
      alarm_prev   <= 1'b0;
    end else begin
      state        <= nxt;
      alarm_prev   <= alarm_in;
      LEDR         <= led_nxt;
      alarm_active <= state != IDLE;
      acked        <= state == ACKED;
      if (enter) begin
        slow_cnt <= '0;
        fast_cnt <= '0;
        slow_ph  <= 1'b1;
        fast_ph  <= 1'b1;
        chase    <= N_LED'(1);
      end else if (state == IDLE) begin
        slow_cnt <= '0;
        fast_cnt <= '0;
      end else begin
        slow_cnt <= slow_wrap ? '0 : slow_cnt + SW'(1);
        fast_cnt <= fast_wrap ? '0 : fast_cnt + FW'(1);
        slow_ph  <= slow_ph ^ slow_wrap;
        fast_ph  <= fast_ph ^ fast_wrap;
        chase    <= fast_wrap ? {chase[N_LED-2:0], chase[N_LED-1]} : chase;
      end
    end
  end
endmodule

// File: tb/tb_led_alarm_ctrl.sv
// tb_led_alarm_ctrl: table-driven scoreboard bench for led_alarm_ctrl at SLOW_HALF=4, FAST_HALF=2.
module tb_led_alarm_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, alarm_in = 1'b0, ack = 1'b0, clear = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [11:0] LEDR;
  logic alarm_active, acked;
  int checks = 0, failures = 0;
  typedef struct {
    string name;
    logic ai, ak, cl;
    logic [1:0] md;
    int n;
    logic [11:0] led;
    logic act, akd;
  } vec_t;
  typedef struct {
    string name;
    logic [11:0] led;
    logic act, akd;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  led_alarm_ctrl #(.N_LED(12), .CLK_HZ(16), .SLOW_HZ(2), .FAST_HZ(4)) dut (
    .clk(clk), .rst_n(rst_n), .alarm_in(alarm_in), .ack(ack), .clear(clear),
    .mode(mode), .LEDR(LEDR), .alarm_active(alarm_active), .acked(acked));
  always #5 clk = ~clk;
  task automatic add(input string name, input logic ai, ak, cl, input logic [1:0] md,
                     input int n, input logic [11:0] led, input logic act, akd);
    vec_t v;
    v.name = name; v.ai = ai; v.ak = ak; v.cl = cl; v.md = md;
    v.n = n; v.led = led; v.act = act; v.akd = akd;
    tbl.push_back(v);
  endtask
  task automatic expect_out(input string name, input logic [11:0] led, input logic act, akd);
    exp_t e;
    e.name = name; e.led = led; e.act = act; e.akd = akd;
    sb.push_back(e);
  endtask
  task automatic compare();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got led=%h act=%b acked=%b with no expectation queued", LEDR, alarm_active, acked);
    end else begin
      e = sb.pop_front();
      if ({LEDR, alarm_active, acked} !== {e.led, e.act, e.akd}) begin
        failures++;
        $display("FAIL %s: got led=%h act=%b acked=%b expected led=%h act=%b acked=%b",
                 e.name, LEDR, alarm_active, acked, e.led, e.act, e.akd);
      end
    end
  endtask
  task automatic step(input string name, input logic ai, ak, cl, input logic [1:0] md,
                      input logic [11:0] led, input logic act, akd);
    alarm_in = ai; ack = ak; clear = cl; mode = md;
    expect_out(name, led, act, akd);
    @(posedge clk);
    #1;
    compare();
  endtask
  initial begin
    add("idle",            0,0,0,0, 2, 12'hFFF,1'b0,1'b0);
    add("alarm_entry",     1,0,0,0, 1, 12'hFFF,1'b0,1'b0);
    add("m0_on",           1,0,0,0, 4, 12'hFFF,1'b1,1'b0);
    add("m0_off",          1,0,0,0, 4, 12'h000,1'b1,1'b0);
    add("m2_555",          1,0,0,2, 4, 12'h555,1'b1,1'b0);
    add("m2_aaa",          1,0,0,2, 4, 12'hAAA,1'b1,1'b0);
    add("ack",             1,1,0,2, 1, 12'h555,1'b1,1'b0);
    add("acked_clr_ign",   1,0,1,2, 1, 12'h001,1'b1,1'b1);
    add("acked_on",        1,0,0,2, 2, 12'h001,1'b1,1'b1);
    add("acked_off",       1,0,0,2, 4, 12'h000,1'b1,1'b1);
    add("acked_drop",      0,0,0,2, 1, 12'h001,1'b1,1'b1);
    add("rise_plus_clear", 1,0,1,3, 1, 12'h001,1'b1,1'b1);
    for (int i = 0; i < 12; i++) add($sformatf("chase_%0d", i), 1,0,0,3, 2, 12'(1 << i), 1'b1, 1'b0);
    add("chase_wrap",      1,0,0,3, 2, 12'h001,1'b1,1'b0);
    add("m1_off",          1,0,0,1, 2, 12'h000,1'b1,1'b0);
    add("m1_on",           1,0,0,1, 2, 12'hFFF,1'b1,1'b0);
    add("ack_and_clear",   1,1,1,1, 1, 12'h000,1'b1,1'b0);
    add("acked_low",       0,0,0,1, 1, 12'h000,1'b1,1'b1);
    add("reenter",         1,0,0,0, 1, 12'h001,1'b1,1'b1);
    add("reenter_fff",     1,0,0,0, 1, 12'hFFF,1'b1,1'b0);
    add("ack2",            1,1,0,0, 1, 12'hFFF,1'b1,1'b0);
    add("acked2_drop",     0,0,0,0, 1, 12'h001,1'b1,1'b1);
    add("clear_to_idle",   0,0,1,0, 1, 12'h001,1'b1,1'b1);
    add("idle_again",      0,0,0,0, 2, 12'hFFF,1'b0,1'b0);
    add("alarm_again",     1,0,0,0, 1, 12'hFFF,1'b0,1'b0);
    add("alarm_clr_ign",   1,0,1,0, 2, 12'hFFF,1'b1,1'b0);
    #3;
    expect_out("in_reset", 12'h000, 1'b0, 1'b0);
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[k])
      for (int c = 0; c < tbl[k].n; c++)
        step(tbl[k].name, tbl[k].ai, tbl[k].ak, tbl[k].cl, tbl[k].md, tbl[k].led, tbl[k].act, tbl[k].akd);
    step("still_alarm", 1,0,0,0, 12'hFFF,1'b1,1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 12'h000, 1'b0, 1'b0);
    compare();
    alarm_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_idle", 0,0,0,0, 12'hFFF,1'b0,1'b0);
    step("post_reset_entry", 1,0,0,0, 12'hFFF,1'b0,1'b0);
    step("post_reset_alarm", 1,0,0,0, 12'hFFF,1'b1,1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
